// File: rtl/aes_pkg.sv
// AES helpers shared by the cipher datapaths: inverse S-box, GF(2^8) doubling chain,
// FSM state encoding and byte-position arithmetic for the 128-bit column-major state.
package aes_pkg;

  localparam int BYTE_W  = 8;
  localparam int N_BYTES = 16;
  localparam int N_COLS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Entry 0x00 sits in the top byte; row k holds entries 16k..16k+15.
  localparam logic [2047:0] INV_SBOX_ROM = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_ROM[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul4(input logic [7:0] b);
    return gf_mul2(gf_mul2(b));
  endfunction

  function automatic logic [7:0] gf_mul8(input logic [7:0] b);
    return gf_mul2(gf_mul4(b));
  endfunction

  // LSB position of state byte i (byte 0 occupies [127:120]).
  function automatic int byte_lsb(input int i);
    return BYTE_W * (N_BYTES - 1 - i);
  endfunction

endpackage

// File: rtl/aes_inv_cipher_core_inv_shift_row.sv
// InvShiftRows: row r of the column-major state rotates right by r columns; pure wiring.
module inv_shift_row
  import aes_pkg::*;
(
  input  logic [127:0] st,
  output logic [127:0] st_isr
);

  for (genvar gi = 0; gi < N_BYTES; gi++) begin : g_byte
    localparam int COL = gi / N_COLS;
    localparam int ROW = gi % N_COLS;
    localparam int SRC = N_COLS * ((COL - ROW + N_COLS) % N_COLS) + ROW;
    assign st_isr[byte_lsb(gi) +: BYTE_W] = st[byte_lsb(SRC) +: BYTE_W];
  end

endmodule

// File: rtl/aes_inv_cipher_core.sv
// Iterative AES inverse cipher: one round per clock, round keys fetched by index from an
// external key store that answers combinationally in the same cycle.
module aes_inv_cipher_core
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_inv_cipher_core: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] LAST_KEY  = 4'(NR);
  localparam logic [3:0] FIRST_MID = 4'(NR - 1);

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m2 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [7:0] o  [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31 - 8 * i -: 8];
      m2[i] = gf_mul2(a[i]);
      m4[i] = gf_mul4(a[i]);
      m8[i] = gf_mul8(a[i]);
    end
    // Row i: 0e*a[i] ^ 0b*a[i+1] ^ 0d*a[i+2] ^ 09*a[i+3]
    for (int i = 0; i < 4; i++) begin
      o[i] = (m8[i] ^ m4[i] ^ m2[i])
           ^ (m8[(i + 1) % 4] ^ m2[(i + 1) % 4] ^ a[(i + 1) % 4])
           ^ (m8[(i + 2) % 4] ^ m4[(i + 2) % 4] ^ a[(i + 2) % 4])
           ^ (m8[(i + 3) % 4] ^ a[(i + 3) % 4]);
    end
    return {o[0], o[1], o[2], o[3]};
  endfunction

  state_e       state_reg, state_next;
  logic [3:0]   cnt_reg, cnt_next;
  logic [127:0] st_reg, st_next;
  logic [127:0] st_isr, st_isb, st_ark, st_imc;

  inv_shift_row u_inv_shift_row (
    .st     (st_reg),
    .st_isr (st_isr)
  );

  for (genvar gi = 0; gi < N_BYTES; gi++) begin : g_sub
    assign st_isb[byte_lsb(gi) +: BYTE_W] = inv_sbox(st_isr[byte_lsb(gi) +: BYTE_W]);
  end

  // Middle rounds and the final round share the AddRoundKey output; only ROUND mixes it.
  assign st_ark = st_isb ^ rk;

  for (genvar gi = 0; gi < N_COLS; gi++) begin : g_mix
    assign st_imc[byte_lsb(N_COLS * gi + 3) +: 32] =
      inv_mix_col(st_ark[byte_lsb(N_COLS * gi + 3) +: 32]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
      st_reg    <= 128'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      st_reg    <= st_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    st_next    = st_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    rk_idx     = LAST_KEY;
    case (state_reg)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          st_next    = in_data ^ rk;
          cnt_next   = FIRST_MID;
          state_next = ST_ROUND;
        end
      end
      ST_ROUND: begin
        rk_idx   = cnt_reg;
        st_next  = st_imc;
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next = ST_FINAL;
        end
      end
      ST_FINAL: begin
        rk_idx     = 4'd0;
        st_next    = st_ark;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign out_data = st_reg;

endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// Bench for aes_inv_cipher_core: independent S-box/key-schedule/encrypt model, scoreboard queue,
// FIPS-197 vectors for NR=10 and NR=14, latency, backpressure, back-to-back and reset abort.
module tb_aes_inv_cipher_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         sel14;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] in_data;

  logic         a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [3:0]   a_rk_idx, b_rk_idx;
  logic [127:0] a_rk, b_rk, a_out_data, b_out_data;
  logic [127:0] rk10 [0:10];
  logic [127:0] rk14 [0:14];

  assign a_rk = (a_rk_idx <= 4'd10) ? rk10[a_rk_idx] : 128'd0;
  assign b_rk = (b_rk_idx <= 4'd14) ? rk14[b_rk_idx] : 128'd0;

  aes_inv_cipher_core #(.NR(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid && !sel14),
    .in_ready  (a_in_ready),
    .in_data   (in_data),
    .rk_idx    (a_rk_idx),
    .rk        (a_rk),
    .out_valid (a_out_valid),
    .out_ready (out_ready),
    .out_data  (a_out_data)
  );

  aes_inv_cipher_core #(.NR(14)) dut14 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid && sel14),
    .in_ready  (b_in_ready),
    .in_data   (in_data),
    .rk_idx    (b_rk_idx),
    .rk        (b_rk),
    .out_valid (b_out_valid),
    .out_ready (out_ready),
    .out_data  (b_out_data)
  );

  logic [127:0] sr_in, sr_out;
  inv_shift_row u_isr (
    .st     (sr_in),
    .st_isr (sr_out)
  );

  logic         obs_in_ready, obs_out_valid;
  logic [3:0]   obs_rk_idx;
  logic [127:0] obs_out_data;
  assign obs_in_ready  = sel14 ? b_in_ready  : a_in_ready;
  assign obs_out_valid = sel14 ? b_out_valid : a_out_valid;
  assign obs_rk_idx    = sel14 ? b_rk_idx    : a_rk_idx;
  assign obs_out_data  = sel14 ? b_out_data  : a_out_data;

  int n_tests;
  int n_fail;
  logic [127:0] exp_q [$];
  logic [7:0]   sbox_tab [256];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // Forward S-box from first principles: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      sbox_tab[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] key, input int nk);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rcon;
    int nr;
    nr   = nk + 6;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i - 1];
      if (i % nk == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i - nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      if (nk == 8) rk14[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
      else         rk10[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    end
  endtask

  function automatic logic [127:0] round_key(input bit use14, input int r);
    return use14 ? rk14[r] : rk10[r];
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input bit use14);
    logic [127:0] s;
    logic [7:0]   b [16];
    logic [7:0]   o [16];
    int nr;
    nr = use14 ? 14 : 10;
    s  = pt ^ round_key(use14, 0);
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) b[i] = sbox_tab[s[127 - 8 * i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) o[4 * c + w] = b[4 * ((c + w) % 4) + w];
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++)
          if (r != nr)
            b[4 * c + j] = gmul(o[4 * c + j], 8'h02) ^ gmul(o[4 * c + (j + 1) % 4], 8'h03)
                         ^ o[4 * c + (j + 2) % 4] ^ o[4 * c + (j + 3) % 4];
          else
            b[4 * c + j] = o[4 * c + j];
      for (int i = 0; i < 16; i++) s[127 - 8 * i -: 8] = b[i];
      s = s ^ round_key(use14, r);
    end
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drives one block from IDLE and follows it to DONE, checking key index and latency.
  task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] pt,
                           input int nr);
    int  lat;
    bit  seen;
    @(negedge clk);
    check({tag, " idle rk_idx"}, 128'(obs_rk_idx), 128'(nr));
    check({tag, " idle in_ready"}, 128'(obs_in_ready), 128'(1));
    in_data  = ct;
    in_valid = 1'b1;
    exp_q.push_back(pt);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      in_valid = 1'b0;
      if (obs_out_valid) begin
        seen = 1'b1;
      end else begin
        check({tag, " rk_idx"}, 128'(obs_rk_idx), 128'((lat <= nr - 1) ? nr - lat : 0));
        check({tag, " busy in_ready"}, 128'(obs_in_ready), 128'(0));
      end
    end
    check({tag, " latency"}, 128'(lat), 128'(nr + 1));
    if (exp_q.size() > 0) check({tag, " data"}, obs_out_data, exp_q.pop_front());
  endtask

  task automatic take_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, " after hs out_valid"}, 128'(obs_out_valid), 128'(0));
    check({tag, " after hs in_ready"}, 128'(obs_in_ready), 128'(1));
    out_ready = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!obs_out_valid && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check({tag, " out_valid"}, 128'(obs_out_valid), 128'(1));
    if (exp_q.size() > 0) check({tag, " data"}, obs_out_data, exp_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] pt, ct, p1, p2, c1, c2;
    int n;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    sel14     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = 128'd0;
    sr_in     = 128'd0;
    build_sbox();
    expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", 128'(obs_in_ready), 128'(1));
    check("reset out_valid", 128'(obs_out_valid), 128'(0));
    check("reset out_data", obs_out_data, 128'd0);
    check("reset rk_idx nr10", 128'(obs_rk_idx), 128'(10));
    sel14 = 1'b1;
    #1;
    check("reset rk_idx nr14", 128'(obs_rk_idx), 128'(14));
    sel14 = 1'b0;
    rst_n = 1'b1;

    sr_in = 128'h000102030405060708090a0b0c0d0e0f;
    #1;
    check("inv_shift_row", sr_out, 128'h000d0a0704010e0b0805020f0c090603);

    run_block("aes128", 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
              128'h00112233445566778899aabbccddeeff, 10);
    take_out("aes128");

    sel14 = 1'b1;
    run_block("aes256", 128'h8ea2b7ca516745bfeafc49904b496089,
              128'h00112233445566778899aabbccddeeff, 14);
    take_out("aes256");
    pt = rand128();
    run_block("aes256 rnd", encrypt(pt, 1'b1), pt, 14);
    take_out("aes256 rnd");
    sel14 = 1'b0;

    for (int k = 0; k < 3; k++) begin
      pt = rand128();
      run_block("aes128 rnd", encrypt(pt, 1'b0), pt, 10);
      take_out("aes128 rnd");
    end

    pt = rand128();
    run_block("bp", encrypt(pt, 1'b0), pt, 10);
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      check("bp out_valid", 128'(obs_out_valid), 128'(1));
      check("bp out_data", obs_out_data, pt);
      check("bp in_ready", 128'(obs_in_ready), 128'(0));
    end
    take_out("bp");

    p1 = rand128();
    p2 = rand128();
    c1 = encrypt(p1, 1'b0);
    c2 = encrypt(p2, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    in_data  = c1;
    in_valid = 1'b1;
    exp_q.push_back(p1);
    @(posedge clk);
    @(negedge clk);
    in_data = c2;
    exp_q.push_back(p2);
    check("b2b busy in_ready", 128'(obs_in_ready), 128'(0));
    wait_out("b2b first");
    @(posedge clk);
    @(negedge clk);
    check("b2b second offered in_ready", 128'(obs_in_ready), 128'(1));
    check("b2b gap out_valid", 128'(obs_out_valid), 128'(0));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b second accepted", 128'(obs_in_ready), 128'(0));
    wait_out("b2b second");
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b done out_valid", 128'(obs_out_valid), 128'(0));

    pt = rand128();
    @(negedge clk);
    in_data  = encrypt(pt, 1'b0);
    in_valid = 1'b1;
    exp_q.push_back(pt);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (obs_rk_idx != 4'd5 && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check("abort at cnt5 rk_idx", 128'(obs_rk_idx), 128'(5));
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("abort out_valid", 128'(obs_out_valid), 128'(0));
    check("abort in_ready", 128'(obs_in_ready), 128'(1));
    check("abort rk_idx", 128'(obs_rk_idx), 128'(10));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort no pulse", 128'(obs_out_valid), 128'(0));
    pt = rand128();
    run_block("post abort", encrypt(pt, 1'b0), pt, 10);
    take_out("post abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
